// File: rtl/osd_ring_router.sv
// rtl/osd_ring_router.sv - debug ring router: ring ingress FIFO, local delivery, round-robin ring-out arbiter
module osd_ring_router #(
    parameter int          PORTS       = 4,
    parameter logic [15:0] ID_BASE     = 16'h0004,
    parameter int          BUF_DEPTH   = 4,
    parameter int          MAX_PKT_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           ring_in_data,
    input  logic                  ring_in_last,
    input  logic                  ring_in_valid,
    output logic                  ring_in_ready,
    output logic [15:0]           ring_out_data,
    output logic                  ring_out_last,
    output logic                  ring_out_valid,
    input  logic                  ring_out_ready,
    input  logic [PORTS*16-1:0]   local_in_data,
    input  logic [PORTS-1:0]      local_in_last,
    input  logic [PORTS-1:0]      local_in_valid,
    output logic [PORTS-1:0]      local_in_ready,
    output logic [PORTS*16-1:0]   local_out_data,
    output logic [PORTS-1:0]      local_out_last,
    output logic [PORTS-1:0]      local_out_valid,
    input  logic [PORTS-1:0]      local_out_ready,
    output logic [15:0]           cnt_local,
    output logic [15:0]           cnt_fwd,
    output logic                  len_err
);
    localparam int AW = $clog2(PORTS + 1);
    localparam int FW = $clog2(BUF_DEPTH);

    localparam logic [1:0] ING_IDLE  = 2'd0;
    localparam logic [1:0] ING_LOCAL = 2'd1;
    localparam logic [1:0] ING_FWD   = 2'd2;
    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_GRANT = 1'b1;

    logic [16:0]   fifo_mem [BUF_DEPTH];
    logic [FW:0]   wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full, push, pop;
    logic [15:0]   head_data;
    logic          head_last;
    logic [16:0]   head_ext;
    logic          head_is_local;

    logic [1:0]    ing_state;
    logic [AW-1:0] ing_port;
    logic          local_rdy_sel, local_pop, fwd_valid, fwd_pop;

    logic [0:0]    arb_state;
    logic [AW-1:0] grant, rr_ptr, pick_idx;
    logic          pick_found;
    logic [PORTS:0] req_vec;
    logic          sel_valid, sel_last, out_accept, arb_xfer;
    logic [15:0]   sel_data;
    logic [15:0]   ing_len, arb_len;

    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_full     = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
    assign ring_in_ready = !fifo_full && !rst;
    assign push          = ring_in_valid && ring_in_ready;
    assign {head_last, head_data} = fifo_mem[rd_ptr[FW-1:0]];
    assign head_ext      = {1'b0, head_data};
    assign head_is_local = (head_ext >= {1'b0, ID_BASE}) && (head_ext < ({1'b0, ID_BASE} + 17'(PORTS)));

    assign fwd_valid  = (ing_state == ING_FWD) && !fifo_empty;
    assign local_pop  = (ing_state == ING_LOCAL) && !fifo_empty && local_rdy_sel;
    assign out_accept = !ring_out_valid || ring_out_ready;
    assign arb_xfer   = (arb_state == ARB_GRANT) && sel_valid && out_accept;
    assign fwd_pop    = arb_xfer && (grant == AW'(PORTS));
    assign pop        = local_pop || fwd_pop;
    assign req_vec    = {fwd_valid, local_in_valid};

    assign local_out_data = {PORTS{head_data}};
    assign local_out_last = {PORTS{head_last}};

    // FIFO storage write; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[FW-1:0]] <= {ring_in_last, ring_in_data};
    end

    // FIFO pointers; a full FIFO refuses pushes even when popping in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (FW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (FW+1)'(1);
        end
    end

    // Per-port steering: local delivery of the FIFO head and the granted ring-out source
    always_comb begin
        local_out_valid = '0;
        local_in_ready  = '0;
        local_rdy_sel   = 1'b0;
        sel_valid       = fwd_valid;
        sel_data        = head_data;
        sel_last        = head_last;
        for (int p = 0; p < PORTS; p++) begin
            if (ing_port == AW'(p)) begin
                local_rdy_sel = local_out_ready[p];
                if (ing_state == ING_LOCAL && !fifo_empty) local_out_valid[p] = 1'b1;
            end
            if (grant == AW'(p)) begin
                sel_valid = local_in_valid[p];
                sel_data  = local_in_data[p*16 +: 16];
                sel_last  = local_in_last[p];
                if (arb_state == ARB_GRANT) local_in_ready[p] = out_accept;
            end
        end
    end

    // Round-robin pick: lowest requester at or after rr_ptr, else lowest overall (wrap)
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = PORTS; i >= 0; i--) begin
            if (req_vec[i]) begin
                pick_found = 1'b1;
                pick_idx   = AW'(i);
            end
        end
        for (int i = PORTS; i >= 0; i--) begin
            if (req_vec[i] && (AW'(i) >= rr_ptr)) pick_idx = AW'(i);
        end
    end

    // Ingress router: classify header at FIFO head, then drain the packet locally or via the arbiter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ing_state <= ING_IDLE;
            ing_port  <= '0;
            cnt_local <= '0;
            cnt_fwd   <= '0;
        end else begin
            case (ing_state)
                ING_IDLE: if (!fifo_empty) begin
                    if (head_is_local) begin
                        ing_state <= ING_LOCAL;
                        ing_port  <= AW'(head_data - ID_BASE);
                    end else begin
                        ing_state <= ING_FWD;
                    end
                end
                ING_LOCAL: if (local_pop && head_last) begin
                    ing_state <= ING_IDLE;
                    if (cnt_local != 16'hFFFF) cnt_local <= cnt_local + 16'd1;
                end
                ING_FWD: if (fwd_pop && head_last) begin
                    ing_state <= ING_IDLE;
                    if (cnt_fwd != 16'hFFFF) cnt_fwd <= cnt_fwd + 16'd1;
                end
                default: ing_state <= ING_IDLE;
            endcase
        end
    end

    // Ring-out arbiter: hold a grant for a whole packet so packets never interleave
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_state <= ARB_IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
        end else begin
            case (arb_state)
                ARB_IDLE: if (pick_found) begin
                    arb_state <= ARB_GRANT;
                    grant     <= pick_idx;
                end
                default: if (arb_xfer && sel_last) begin
                    arb_state <= ARB_IDLE;
                    rr_ptr    <= (grant == AW'(PORTS)) ? '0 : grant + AW'(1);
                end
            endcase
        end
    end

    // Ring-out register: loads whenever it is empty or being drained downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring_out_valid <= 1'b0;
            ring_out_data  <= '0;
            ring_out_last  <= 1'b0;
        end else if (out_accept) begin
            ring_out_valid <= arb_xfer;
            if (arb_xfer) begin
                ring_out_data <= sel_data;
                ring_out_last <= sel_last;
            end
        end
    end

    // Packet length policing on both paths; oversized packets still pass, only the flag sticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ing_len <= '0;
            arb_len <= '0;
            len_err <= 1'b0;
        end else begin
            if (pop) begin
                if (ing_len == 16'(MAX_PKT_LEN) && !head_last) len_err <= 1'b1;
                ing_len <= head_last ? '0 : ((ing_len == 16'hFFFF) ? ing_len : ing_len + 16'd1);
            end
            if (arb_xfer) begin
                if (arb_len == 16'(MAX_PKT_LEN) && !sel_last) len_err <= 1'b1;
                arb_len <= sel_last ? '0 : ((arb_len == 16'hFFFF) ? arb_len : arb_len + 16'd1);
            end
        end
    end
endmodule

// File: doc/osd_ring_router.md
OSD_RING_ROUTER -- requirements
Module: osd_ring_router

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of local debug module ports (1..16).
REQ-002 SHALL have parameter ID_BASE, default 16'h0004, debug ID of local port 0; port p has ID ID_BASE+p.
REQ-003 SHALL have parameter BUF_DEPTH, default 4, ring-ingress FIFO depth in flits (power of 2, >=2).
REQ-004 SHALL have parameter MAX_PKT_LEN, default 16, maximum legal flits per packet.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 ring_in_data/last/valid  input  16/1/1  upstream ring flit.
REQ-009 ring_in_ready  output  1  ring ingress FIFO can accept.
REQ-010 ring_out_data/last/valid  output  16/1/1  downstream ring flit, registered.
REQ-011 ring_out_ready  input  1  downstream accepts.
REQ-012 local_in_data/last/valid  input  PORTS*16/PORTS/PORTS  flits from local modules.
REQ-013 local_in_ready  output  PORTS  per-port accept.
REQ-014 local_out_data/last/valid  output  PORTS*16/PORTS/PORTS  flits to local modules.
REQ-015 local_out_ready  input  PORTS  per-port accept.
REQ-016 cnt_local, cnt_fwd  output  16 each  saturating counts of ring packets delivered locally / forwarded.
REQ-017 len_err  output  1  sticky packet-length violation flag.

Function
REQ-018 Transfer occurs on any interface when valid and ready are both high at a clock edge; valid, data, last SHALL be held stable until transfer.
REQ-019 First flit of a packet is header; data[15:0] is destination ID.
REQ-020 Ring ingress: flits enter a BUF_DEPTH FIFO; ring_in_ready = FIFO not full and rst low; no push when full, even with simultaneous pop.
REQ-021 Ingress router states IDLE, LOCAL, FWD; in IDLE at FIFO head header: dest in [ID_BASE, ID_BASE+PORTS-1] -> LOCAL with port = dest-ID_BASE, else FWD.
REQ-022 LOCAL: FIFO head drives local_out[port] combinationally; pop on transfer; return to IDLE after last flit transfers; cnt_local increments at that transfer.
REQ-023 FWD: FIFO head is requester PORTS of ring-out arbiter; return to IDLE after last flit transfers; cnt_fwd increments then.
REQ-024 Stalled local_out SHALL block the FIFO head (head-of-line blocking); no reordering.
REQ-025 Ring-out arbiter: requesters local_in[0..PORTS-1] and ring pass-through (index PORTS); states IDLE, GRANT.
REQ-026 IDLE: grant first valid requester at or after round-robin pointer (wrapping); GRANT held until granted packet's last flit transfers, then pointer = grant+1 mod (PORTS+1), back to IDLE.
REQ-027 Packets SHALL never interleave on ring_out; non-granted local_in_ready = 0.
REQ-028 ring_out output register accepts when empty or ring_out_ready high; latency from local_in or FIFO head transfer to ring_out_valid is exactly 1 cycle; full throughput 1 flit/cycle.
REQ-029 Local-input packets always go to ring_out, even if addressed to a local ID.
REQ-030 Per-path flit counters: a flit numbered MAX_PKT_LEN+1 without last sets len_err; packet still passes unchanged.
REQ-031 Counters saturate at 16'hFFFF.

Reset
REQ-032 On rst: FIFO empty, both FSMs IDLE, pointer 0, output register empty, counters 0, len_err 0.
REQ-033 While rst high: all *_valid and *_ready outputs 0; reset mid-packet discards partial packet, no recovery.

Verification (PORTS=4, ID_BASE=8, BUF_DEPTH=4, MAX_PKT_LEN=8)
REQ-034 ring_in 3-flit packet header 16'h000A -> identical 3 flits on local_out[2], ring_out idle, cnt_local=1.
REQ-035 ring_in packet header 16'h0014 -> same flits on ring_out one cycle after each pop, cnt_fwd=1.
REQ-036 local_in[0], local_in[3] present 2-flit packets same cycle, pointer 0 -> port 0 packet complete, then port 3, no interleave, pointer ends 4.
REQ-037 local_out_ready[1]=0, send 5-flit packet to ID 9 -> exactly 4 flits accepted, then ring_in_ready=0 until ready released.
REQ-038 10-flit packet, last on flit 10 -> len_err rises with flit 9 transfer, stays 1 until rst.
REQ-039 rst pulsed during flit 2 of 4-flit forward -> all valids 0 next, counters 0, next packet routes normally.
